// File: rtl/lcd_pixel_feeder.sv
// Elastic RGB565 pixel source for the LCD driver: buffers the upstream stream in a FIFO,
// locks each source frame to the driver's first active pixel, and counts underflows/resyncs.
module lcd_pixel_feeder #(
  parameter int          H_DISP      = 800,
  parameter int          V_DISP      = 480,
  parameter int          FIFO_DEPTH  = 512,
  parameter logic [15:0] BLANK_COLOR = 16'h0000,
  parameter logic [15:0] UFLOW_COLOR = 16'hF800
) (
  input  logic        lcd_clk,
  input  logic        rst,
  input  logic [15:0] src_data,
  input  logic        src_valid,
  input  logic        src_sof,
  output logic        src_ready,
  input  logic        data_req,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic [15:0] lcd_data,
  output logic [15:0] underflow_cnt,
  output logic [15:0] resync_cnt,
  output logic        locked
);

  localparam int DATA_W    = 16;
  localparam int FRAME_PIX = H_DISP * V_DISP;
  localparam int CW        = $clog2(FRAME_PIX + 1);
  localparam int AW        = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                    state, state_nxt;
  logic [DATA_W-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]             wr_cnt, rd_cnt;
  logic                      full, empty, below_frame;
  logic                      frame_start, accept, start, resync;
  logic                      pop_req, pop, uflow, wr, last;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty       = (wr_ptr == rd_ptr);
  assign below_frame = (wr_cnt < CW'(FRAME_PIX));
  assign frame_start = data_req && (pixel_xpos == 11'd0) && (pixel_ypos == 11'd1);

  // Event decode. A sof beat always restarts the FIFO at entry 0, and it
  // outranks a same-cycle pop so the driver sees blank rather than a stale pixel.
  always_comb begin
    accept  = src_valid && src_ready;
    start   = accept && src_sof;
    resync  = start && (state != IDLE);
    pop_req = data_req && ((state == RUN) || ((state == FILL) && frame_start));
    uflow   = pop_req && empty && !start;
    pop     = pop_req && !empty && !start;
    wr      = accept && (state != IDLE) && !start;
    last    = pop && (rd_cnt == CW'(FRAME_PIX - 1));
  end

  always_ff @(posedge lcd_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)                     state_nxt = FILL;
    else if (uflow || last)        state_nxt = IDLE;
    else if (pop && state == FILL) state_nxt = RUN;
  end

  always_comb begin
    src_ready = 1'b0;
    locked    = 1'b0;
    case (state)
      IDLE: src_ready = 1'b1;
      FILL: src_ready = !full && below_frame;
      RUN: begin
        src_ready = !full && below_frame;
        locked    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge lcd_clk) begin
    if (start)   mem[0]                <= src_data;
    else if (wr) mem[wr_ptr[AW-1:0]]   <= src_data;
  end

  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      lcd_data      <= '0;
      underflow_cnt <= '0;
      resync_cnt    <= '0;
    end else begin
      if (data_req) begin
        if (uflow)    lcd_data <= UFLOW_COLOR;
        else if (pop) lcd_data <= mem[rd_ptr[AW-1:0]];
        else          lcd_data <= BLANK_COLOR;
      end
      if (start) begin
        wr_ptr <= (AW+1)'(1);
        rd_ptr <= '0;
        wr_cnt <= CW'(1);
        rd_cnt <= '0;
      end else if (uflow) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        wr_cnt <= '0;
        rd_cnt <= '0;
      end else begin
        if (wr) begin
          wr_ptr <= wr_ptr + (AW+1)'(1);
          wr_cnt <= wr_cnt + CW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + (AW+1)'(1);
          rd_cnt <= rd_cnt + CW'(1);
        end
        // Frame fully displayed: every written pixel has been read, FIFO is empty.
        if (last) begin
          wr_cnt <= '0;
          rd_cnt <= '0;
        end
      end
      if (uflow)  underflow_cnt <= sat_inc(underflow_cnt);
      if (resync) resync_cnt    <= sat_inc(resync_cnt);
    end
  end

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Directed bench for lcd_pixel_feeder with a small frame (4x2) and a 4-entry FIFO.
module tb_lcd_pixel_feeder;

  logic        lcd_clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] src_data = '0;
  logic        src_valid = 1'b0;
  logic        src_sof = 1'b0;
  logic        src_ready;
  logic        data_req = 1'b0;
  logic [10:0] pixel_xpos = '0;
  logic [10:0] pixel_ypos = '0;
  logic [15:0] lcd_data;
  logic [15:0] underflow_cnt;
  logic [15:0] resync_cnt;
  logic        locked;

  int total = 0;
  int bad   = 0;

  lcd_pixel_feeder #(
    .H_DISP(4), .V_DISP(2), .FIFO_DEPTH(4),
    .BLANK_COLOR(16'h0000), .UFLOW_COLOR(16'hF800)
  ) dut (
    .lcd_clk(lcd_clk), .rst(rst),
    .src_data(src_data), .src_valid(src_valid), .src_sof(src_sof), .src_ready(src_ready),
    .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .lcd_data(lcd_data), .underflow_cnt(underflow_cnt), .resync_cnt(resync_cnt),
    .locked(locked)
  );

  always #5 lcd_clk = ~lcd_clk;

  typedef struct {
    logic        v, s;
    logic [15:0] d;
    logic        r;
    logic [10:0] x, y;
    logic [15:0] lcd;
    logic        rdy, lck;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic v, s, input logic [15:0] d, input logic r,
                              input logic [10:0] x, y, input logic [15:0] lcd,
                              input logic rdy, lck);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.r = r; t.x = x; t.y = y;
    t.lcd = lcd; t.rdy = rdy; t.lck = lck;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic step(input logic v, s, input logic [15:0] d, input logic r,
                      input logic [10:0] x, y);
    @(negedge lcd_clk);
    src_valid = v; src_sof = s; src_data = d;
    data_req = r; pixel_xpos = x; pixel_ypos = y;
    @(posedge lcd_clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 11'd5, 11'd5);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Full frame through a FIFO half the frame size, then requests while idle.
    tbl[0]  = mk(1, 1, 16'h0001, 0, 5, 5, 16'h0000, 1, 0);
    tbl[1]  = mk(1, 0, 16'h0002, 0, 5, 5, 16'h0000, 1, 0);
    tbl[2]  = mk(1, 0, 16'h0003, 0, 5, 5, 16'h0000, 1, 0);
    tbl[3]  = mk(1, 0, 16'h0004, 0, 5, 5, 16'h0000, 0, 0);
    tbl[4]  = mk(0, 0, 16'h0000, 1, 0, 1, 16'h0001, 1, 1);
    tbl[5]  = mk(1, 0, 16'h0005, 1, 1, 1, 16'h0002, 1, 1);
    tbl[6]  = mk(1, 0, 16'h0006, 1, 2, 1, 16'h0003, 1, 1);
    tbl[7]  = mk(1, 0, 16'h0007, 1, 3, 1, 16'h0004, 1, 1);
    tbl[8]  = mk(1, 0, 16'h0008, 1, 0, 2, 16'h0005, 0, 1);
    tbl[9]  = mk(1, 0, 16'h0009, 1, 1, 2, 16'h0006, 0, 1);
    tbl[10] = mk(0, 0, 16'h0000, 1, 2, 2, 16'h0007, 0, 1);
    tbl[11] = mk(0, 0, 16'h0000, 1, 3, 2, 16'h0008, 1, 0);
    tbl[12] = mk(0, 0, 16'h0000, 0, 5, 5, 16'h0008, 1, 0);
    tbl[13] = mk(0, 0, 16'h0000, 1, 0, 1, 16'h0000, 1, 0);
    tbl[14] = mk(0, 0, 16'h0000, 1, 1, 1, 16'h0000, 1, 0);

    do_reset();
    chk("reset_lcd", lcd_data, 16'h0000);
    chk("reset_ready", 16'(src_ready), 16'h1);
    chk("reset_locked", 16'(locked), 16'h0);
    chk("reset_ucnt", underflow_cnt, 16'h0);
    chk("reset_rcnt", resync_cnt, 16'h0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r, tbl[i].x, tbl[i].y);
      chk($sformatf("vec%0d_lcd", i), lcd_data, tbl[i].lcd);
      chk($sformatf("vec%0d_ready", i), 16'(src_ready), 16'(tbl[i].rdy));
      chk($sformatf("vec%0d_locked", i), 16'(locked), 16'(tbl[i].lck));
      chk($sformatf("vec%0d_ucnt", i), underflow_cnt, 16'h0);
      chk($sformatf("vec%0d_rcnt", i), resync_cnt, 16'h0);
    end

    // Non-sof beats in IDLE are dropped; the sof beat is the first pixel shown.
    do_reset();
    step(1, 0, 16'h0011, 0, 5, 5);
    step(1, 0, 16'h0012, 0, 5, 5);
    step(1, 0, 16'h0013, 0, 5, 5);
    step(1, 1, 16'hAAAA, 0, 5, 5);
    chk("drop_locked_fill", 16'(locked), 16'h0);
    step(0, 0, 16'h0, 1, 0, 1);
    chk("drop_first_pixel", lcd_data, 16'hAAAA);
    chk("drop_locked_run", 16'(locked), 16'h1);
    step(0, 0, 16'h0, 1, 1, 1);
    chk("drop_then_uflow", lcd_data, 16'hF800);
    chk("drop_ucnt", underflow_cnt, 16'h0001);

    // Source stalls after two beats.
    do_reset();
    step(1, 1, 16'h0001, 0, 5, 5);
    step(1, 0, 16'h0002, 0, 5, 5);
    step(0, 0, 16'h0, 1, 0, 1);
    chk("stall_px0", lcd_data, 16'h0001);
    step(0, 0, 16'h0, 1, 1, 1);
    chk("stall_px1", lcd_data, 16'h0002);
    step(0, 0, 16'h0, 1, 2, 1);
    chk("stall_uflow_px", lcd_data, 16'hF800);
    chk("stall_ucnt", underflow_cnt, 16'h0001);
    chk("stall_locked", 16'(locked), 16'h0);
    step(0, 0, 16'h0, 1, 0, 1);
    chk("stall_idle_blank", lcd_data, 16'h0000);
    chk("stall_ucnt_hold", underflow_cnt, 16'h0001);

    // Reset mid-RUN with traffic active.
    step(1, 1, 16'h0001, 0, 5, 5);
    step(1, 0, 16'h0002, 0, 5, 5);
    step(1, 0, 16'h0003, 0, 5, 5);
    step(0, 0, 16'h0, 1, 0, 1);
    chk("rst_pre_px", lcd_data, 16'h0001);
    chk("rst_pre_locked", 16'(locked), 16'h1);
    rst = 1'b1;
    step(1, 0, 16'h0009, 1, 1, 1);
    chk("rst_lcd", lcd_data, 16'h0000);
    chk("rst_locked", 16'(locked), 16'h0);
    chk("rst_ucnt", underflow_cnt, 16'h0000);
    rst = 1'b0;
    idle();
    chk("rst_ready_after", 16'(src_ready), 16'h1);
    step(0, 0, 16'h0, 1, 0, 1);
    chk("rst_fifo_empty_blank", lcd_data, 16'h0000);
    chk("rst_no_uflow", underflow_cnt, 16'h0000);
    step(1, 1, 16'h00C0, 0, 5, 5);
    step(0, 0, 16'h0, 1, 0, 1);
    chk("rst_new_frame_px", lcd_data, 16'h00C0);

    // Early sof mid-frame together with a request.
    do_reset();
    step(1, 1, 16'h0001, 0, 5, 5);
    step(1, 0, 16'h0002, 0, 5, 5);
    step(1, 0, 16'h0003, 0, 5, 5);
    step(1, 0, 16'h0004, 0, 5, 5);
    chk("resync_full_ready", 16'(src_ready), 16'h0);
    step(0, 0, 16'h0, 1, 0, 1);
    chk("resync_px0", lcd_data, 16'h0001);
    step(0, 0, 16'h0, 1, 1, 1);
    chk("resync_px1", lcd_data, 16'h0002);
    step(1, 0, 16'h0005, 0, 5, 5);
    step(1, 1, 16'h0BAD, 1, 2, 1);
    chk("resync_blank", lcd_data, 16'h0000);
    chk("resync_rcnt", resync_cnt, 16'h0001);
    chk("resync_locked", 16'(locked), 16'h0);
    chk("resync_ucnt", underflow_cnt, 16'h0000);
    step(0, 0, 16'h0, 1, 0, 1);
    chk("resync_first_px", lcd_data, 16'h0BAD);
    chk("resync_relock", 16'(locked), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
